mem_seq: RTL and testbench

Memory access sequencer for the 16-bit CPU. It is the driving side of the instruction-register load interface. It runs instruction fetches, data reads and data writes against a variable-latency memory using a ready handshake. It emits the `rec` load code that tells the IR (`2'b10`) or the data register (`2'b01`) to capture `mem_rdata` on the closing clock edge of the access. It sits between the control unit (requests) and the memory bus, next to the IR.

---
 rtl/mem_seq.sv | 118 +++++++++++
 tb/tb_mem_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_seq.sv
// Memory access sequencer: runs fetch / data read / data write cycles against a
// ready-handshake memory and drives the IR / data-register load code.
module mem_seq #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic        rw_req,
    input  logic        rw_we,
    input  logic [15:0] pc,
    input  logic [15:0] data_addr,
    input  logic [15:0] wdata,
    input  logic        err_clr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd_n,
    output logic        mem_wr_n,
    output logic [1:0]  rec,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_LATCH,
        S_ERR
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic        w_active;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;
    logic        r_is_fetch;
    logic        r_we;
    logic        r_terr;
    logic [7:0]  r_cnt;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            // LATCH's closing edge doubles as the IDLE accept point, giving
            // back-to-back accesses with no idle cycle in between.
            S_IDLE, S_LATCH: begin
                if (rw_req || fetch_req) begin
                    w_accept = 1'b1;
                    w_next   = S_ADDR;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ADDR: w_next = S_WAIT;
            S_WAIT: begin
                if (mem_ready)
                    w_next = S_LATCH;
                else if (32'(r_cnt) + 32'd1 >= TIMEOUT)
                    w_next = S_ERR;
            end
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_is_fetch <= 1'b0;
            r_we       <= 1'b0;
            r_terr     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_is_fetch <= !rw_req;
                r_we       <= rw_req && rw_we;
                r_addr     <= rw_req ? data_addr : pc;
                r_wdata    <= wdata;
                r_cnt      <= '0;
            end else if (r_state == S_WAIT && !mem_ready) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_state == S_LATCH && !r_is_fetch && !r_we)
                r_rdata <= mem_rdata;
            // A set in ERR overrides a simultaneous clear.
            if (r_state == S_ERR)
                r_terr <= 1'b1;
            else if (err_clr)
                r_terr <= 1'b0;
        end
    end

    assign w_active    = (r_state == S_ADDR) || (r_state == S_WAIT) || (r_state == S_LATCH);
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign mem_rd_n    = !(w_active && !r_we);
    assign mem_wr_n    = !(w_active && r_we);
    assign rec         = (r_state != S_LATCH) ? 2'b00 :
                         r_is_fetch           ? 2'b10 :
                         !r_we                ? 2'b01 : 2'b00;
    assign rdata       = r_rdata;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_LATCH);
    assign timeout_err = r_terr;

endmodule

// File: tb/tb_mem_seq.sv
// Scoreboard bench for mem_seq: the driver plays requester and memory and queues
// expected completions; a negedge monitor checks every done / timeout event.
module tb_mem_seq;

    localparam int unsigned TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req, rw_req, rw_we, err_clr, mem_ready;
    logic [15:0] pc, data_addr, wdata, mem_rdata;
    logic [15:0] mem_addr, mem_wdata, rdata;
    logic        mem_rd_n, mem_wr_n, busy, done, timeout_err;
    logic [1:0]  rec;

    mem_seq #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .rw_req(rw_req), .rw_we(rw_we),
        .pc(pc), .data_addr(data_addr), .wdata(wdata), .err_clr(err_clr),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rd_n(mem_rd_n), .mem_wr_n(mem_wr_n), .rec(rec),
        .rdata(rdata), .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    // kind: 0 fetch, 1 data read, 2 write
    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
        int          w;
        bit          to;
        longint      acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        me;
    int          total = 0;
    int          bad = 0;
    longint      cyc = 0;
    logic [15:0] ir;
    bit          in_reset = 0, keep_fetch = 0, need_clr = 0;
    bit          pend_rd = 0, pend_ir = 0;
    logic [15:0] pend_val;
    logic        prev_te = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instruction register consumer of the load code.
    always @(posedge clk or negedge reset)
        if (!reset) ir <= '0;
        else if (rec == 2'b10) ir <= mem_rdata;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!in_reset) begin
            if (pend_rd) begin chk("rdata_latched", rdata, pend_val); pend_rd = 0; end
            if (pend_ir) begin chk("ir_loaded", ir, pend_val); pend_ir = 0; end
            if (rec != 2'b00 && !done) chk("rec_outside_latch", rec, 0);
            if (done) begin
                if (sb.size() == 0) chk("unexpected_done", sb.size(), 1);
                else begin
                    me = sb.pop_front();
                    chk("done_not_timeout", me.to, 0);
                    chk("done_cycle", cyc, me.acc + me.w + 2);
                    chk("rec_code", rec, (me.kind == 0) ? 2 : (me.kind == 1) ? 1 : 0);
                    chk("latch_addr", mem_addr, me.addr);
                    chk("latch_rd_n", mem_rd_n, me.kind == 2);
                    chk("latch_wr_n", mem_wr_n, me.kind != 2);
                    if (me.kind == 2) chk("latch_wdata", mem_wdata, me.data);
                    if (me.kind == 1) begin pend_rd = 1; pend_val = me.data; end
                    if (me.kind == 0) begin pend_ir = 1; pend_val = me.data; end
                end
            end
            if (timeout_err && !prev_te) begin
                if (sb.size() == 0) chk("unexpected_timeout", sb.size(), 1);
                else begin
                    me = sb.pop_front();
                    chk("timeout_expected", me.to, 1);
                    chk("timeout_cycle", cyc, me.acc + TO + 2);
                    chk("timeout_rd_n", mem_rd_n, 1);
                    chk("timeout_wr_n", mem_wr_n, 1);
                end
            end
        end
        prev_te = timeout_err;
    end

    // One access: starts at a negedge where the DUT is IDLE or in LATCH.
    task automatic issue(input int kind, input logic [15:0] a, input logic [15:0] d,
                         input int w, input bit to);
        exp_t e;
        bit   clr;
        @(negedge clk);
        clr       = need_clr;
        err_clr   = need_clr;
        need_clr  = 0;
        rw_req    = (kind != 0);
        rw_we     = (kind == 0) ? 1'($urandom) : (kind == 2);
        fetch_req = (kind == 0) || keep_fetch;
        if (kind == 0) begin pc = a; data_addr = 16'($urandom); end
        else begin data_addr = a; if (!keep_fetch) pc = 16'($urandom); end
        wdata     = (kind == 2) ? d : 16'($urandom);
        mem_ready = 1'b0;
        e.kind = kind; e.addr = a; e.data = d; e.w = w; e.to = to; e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        rw_req    = 1'b0;
        fetch_req = keep_fetch;
        err_clr   = 1'b0;
        mem_ready = 1'($urandom);
        mem_rdata = 16'($urandom);
        if (clr) chk("err_clr", timeout_err, 0);
        @(posedge clk);
        repeat (to ? int'(TO) : w) begin
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = 16'($urandom);
            fetch_req = keep_fetch | ($urandom_range(0, 3) == 0);
            rw_req    = ($urandom_range(0, 3) == 0);
            @(posedge clk);
        end
        @(negedge clk);
        rw_req    = 1'b0;
        fetch_req = keep_fetch;
        if (to) begin
            chk("err_rd_n", mem_rd_n, 1);
            chk("err_wr_n", mem_wr_n, 1);
            chk("err_done", done, 0);
            chk("err_rec", rec, 0);
            chk("err_busy", busy, 1);
            err_clr  = 1'($urandom);
            need_clr = 1;
        end else begin
            mem_ready = 1'b1;
            mem_rdata = d;
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rw_req = 1'b0; fetch_req = 1'b0; mem_ready = 1'($urandom);
            @(posedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k, w, w2;
        bit          to;
        logic [15:0] p;
        reset = 1'b1; fetch_req = 0; rw_req = 0; rw_we = 0; err_clr = 0; mem_ready = 0;
        pc = '0; data_addr = '0; wdata = '0; mem_rdata = '0;
        #1 reset = 1'b0;
        #2;
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rd_n", mem_rd_n, 1);
        chk("rst_wr_n", mem_wr_n, 1);
        chk("rst_rec", rec, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout_err", timeout_err, 0);
        @(negedge clk) reset = 1'b1;

        issue(0, 16'h0040, 16'hA5C3, 0, 0);
        issue(1, 16'h1234, 16'h00FF, 3, 0);
        issue(2, 16'h2000, 16'hBEEF, 0, 0);
        issue(1, 16'h0F0F, 16'h8001, TO - 1, 0);
        issue(1, 16'h4444, 16'h0000, 0, 1);
        pc = 16'h0100; keep_fetch = 1;
        issue(1, 16'h3000, 16'h5A5A, 0, 0);
        keep_fetch = 0;
        issue(0, 16'h0100, 16'h1357, 0, 0);
        idle(1);

        for (int i = 0; i < 40; i++) begin
            k  = $urandom_range(0, 2);
            to = ($urandom_range(0, 7) == 0);
            w  = $urandom_range(0, 5);
            if (k != 0 && !to && $urandom_range(0, 3) == 0) begin
                p = 16'($urandom); pc = p; keep_fetch = 1;
                issue(k, 16'($urandom), 16'($urandom), w, 0);
                keep_fetch = 0;
                w2 = $urandom_range(0, 3);
                issue(0, p, 16'($urandom), w2, 0);
            end else begin
                issue(k, 16'($urandom), 16'($urandom), w, to);
            end
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end

        // Asynchronous reset in the middle of a WAIT, with timeout_err set.
        issue(2, 16'h5555, 16'h1111, 0, 1);
        @(negedge clk);
        err_clr = 0; fetch_req = 1; pc = 16'h0ABC; mem_ready = 0;
        @(posedge clk);
        @(negedge clk) fetch_req = 0;
        @(posedge clk);
        @(negedge clk);
        in_reset = 1;
        #1 reset = 1'b0;
        #1;
        chk("arst_rd_n", mem_rd_n, 1);
        chk("arst_wr_n", mem_wr_n, 1);
        chk("arst_rec", rec, 0);
        chk("arst_done", done, 0);
        chk("arst_busy", busy, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_rdata", rdata, 0);
        chk("arst_timeout_err", timeout_err, 0);
        need_clr = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        in_reset = 0;
        issue(0, 16'h0040, 16'h7E81, 1, 0);
        issue(1, 16'h0042, 16'h2468, 0, 0);
        idle(4);
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
